// File: rtl/cci_mpf_csrs_pkg.sv
// Shared CSR definitions for the MPF control block: index map, event bit
// positions, STATUS layout and the configuration types driven to VTP.
package cci_mpf_csrs_pkg;

  localparam int CL_ADDR_W = 42;
  typedef logic [CL_ADDR_W-1:0] t_cci_clAddr;

  typedef struct packed {
    logic inval_translation_cache;
    logic enabled;
  } t_cci_mpf_vtp_csr_mode;

  localparam int VTP_MODE_W = $bits(t_cci_mpf_vtp_csr_mode);

  localparam logic [3:0] CSR_IDX_VTP_MODE    = 4'd0;
  localparam logic [3:0] CSR_IDX_VTP_PT_BASE = 4'd1;
  localparam logic [3:0] CSR_IDX_VC_MAP_CTRL = 4'd2;
  localparam logic [3:0] CSR_IDX_EVT_CLEAR   = 4'd3;
  localparam logic [3:0] CSR_IDX_STATUS      = 4'd4;
  localparam logic [3:0] CSR_IDX_EVT_BASE    = 4'd8;
  localparam logic [3:0] CSR_IDX_EVT_LAST    = 4'd14;

  localparam int N_EVT                  = 7;
  localparam int EVT_4KB_HIT            = 0;
  localparam int EVT_4KB_MISS           = 1;
  localparam int EVT_2MB_HIT            = 2;
  localparam int EVT_2MB_MISS           = 3;
  localparam int EVT_PT_WALK_BUSY       = 4;
  localparam int EVT_FAILED_TRANSLATION = 5;
  localparam int EVT_VC_MAP_CHANGED     = 6;

  localparam int STATUS_FIFO_FULL_BIT   = 0;
  localparam int STATUS_OVERFLOW_BIT    = 1;
  localparam int EVT_CLEAR_OVERFLOW_BIT = 63;

endpackage

// File: rtl/cci_mpf_csr_evt_ctr.sv
// One saturating event counter; a clear beats a simultaneous increment.
module cci_mpf_csr_evt_ctr #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cci_mpf_csr_ctrl.sv
// MPF host CSR block: config write decode, event counters (only when
// MPF_CSR_EVENT_COUNTERS_EN is defined) and a buffered read-response path.
module cci_mpf_csr_ctrl
  import cci_mpf_csrs_pkg::*;
#(
  parameter int RSP_FIFO_DEPTH = 4,
  parameter int EVT_CTR_BITS   = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mmio_wr_valid,
  input  logic [3:0]            mmio_wr_idx,
  input  logic [63:0]           mmio_wr_data,
  input  logic                  mmio_rd_valid,
  input  logic [3:0]            mmio_rd_idx,
  input  logic [8:0]            mmio_rd_tid,
  output logic                  rsp_valid,
  output logic [8:0]            rsp_tid,
  output logic [63:0]           rsp_data,
  input  logic                  rsp_ready,
  input  logic [6:0]            evt_in,
  output t_cci_mpf_vtp_csr_mode vtp_mode,
  output t_cci_clAddr           vtp_pt_base,
  output logic                  vtp_pt_base_valid,
  output logic [63:0]           vc_map_ctrl,
  output logic                  vc_map_ctrl_valid
);

  localparam int PW = $clog2(RSP_FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [EVT_CTR_BITS-1:0] ctr [N_EVT];
  logic                    evt_clr_wr;
  logic                    sticky_overflow;
  logic                    fifo_full;
  logic [63:0]             rd_data;
  logic [2:0]              ctr_sel;

  assign evt_clr_wr = mmio_wr_valid && (mmio_wr_idx == CSR_IDX_EVT_CLEAR);

  always_ff @(posedge clk) begin
    if (reset) begin
      vtp_mode          <= '0;
      vtp_pt_base       <= '0;
      vc_map_ctrl       <= '0;
      vtp_pt_base_valid <= 1'b0;
      vc_map_ctrl_valid <= 1'b0;
    end else begin
      vtp_pt_base_valid <= 1'b0;
      vc_map_ctrl_valid <= 1'b0;
      if (mmio_wr_valid) begin
        case (mmio_wr_idx)
          CSR_IDX_VTP_MODE:
            vtp_mode <= t_cci_mpf_vtp_csr_mode'(mmio_wr_data[VTP_MODE_W-1:0]);
          CSR_IDX_VTP_PT_BASE: begin
            vtp_pt_base       <= mmio_wr_data[CL_ADDR_W-1:0];
            vtp_pt_base_valid <= 1'b1;
          end
          CSR_IDX_VC_MAP_CTRL: begin
            vc_map_ctrl       <= mmio_wr_data;
            vc_map_ctrl_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef MPF_CSR_EVENT_COUNTERS_EN
  for (genvar i = 0; i < N_EVT; i++) begin : g_ctr
    cci_mpf_csr_evt_ctr #(.W(EVT_CTR_BITS)) u_ctr (
      .clk   (clk),
      .reset (reset),
      .clr   (evt_clr_wr && mmio_wr_data[i]),
      .inc   (evt_in[i]),
      .count (ctr[i])
    );
  end
`else
  logic evt_unused;
  assign evt_unused = ^evt_in;
  for (genvar i = 0; i < N_EVT; i++) begin : g_ctr
    assign ctr[i] = '0;
  end
`endif

  // Reads see register state before any same-cycle write or event update.
  assign ctr_sel = 3'(mmio_rd_idx - CSR_IDX_EVT_BASE);
  always_comb begin
    rd_data = '0;
    case (mmio_rd_idx)
      CSR_IDX_VTP_MODE:    rd_data = 64'(vtp_mode);
      CSR_IDX_VTP_PT_BASE: rd_data = 64'(vtp_pt_base);
      CSR_IDX_VC_MAP_CTRL: rd_data = vc_map_ctrl;
      CSR_IDX_STATUS: begin
        rd_data[STATUS_FIFO_FULL_BIT] = fifo_full;
        rd_data[STATUS_OVERFLOW_BIT]  = sticky_overflow;
      end
      default: begin
        if ((mmio_rd_idx >= CSR_IDX_EVT_BASE) && (mmio_rd_idx <= CSR_IDX_EVT_LAST))
          rd_data = 64'(ctr[ctr_sel]);
      end
    endcase
  end

  // Response handshake: a beat transfers on a rising edge where rsp_valid and
  // rsp_ready are both high; while rsp_ready is low the head beat is held.
  logic              p_valid;
  logic [8:0]        p_tid;
  logic [63:0]       p_data;
  logic [CW-1:0]     fifo_cnt;
  logic [CW-1:0]     occ_next;
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [8:0]        mem_tid  [RSP_FIFO_DEPTH];
  logic [63:0]       mem_data [RSP_FIFO_DEPTH];
  logic              deq;
  logic              rd_accept;

  assign rsp_valid = (fifo_cnt != '0);
  assign rsp_tid   = mem_tid[rd_ptr];
  assign rsp_data  = mem_data[rd_ptr];
  assign fifo_full = (fifo_cnt == CW'(RSP_FIFO_DEPTH));
  assign deq       = rsp_valid && rsp_ready;

  // The in-flight pipeline entry already owns a FIFO slot for next cycle.
  assign occ_next  = fifo_cnt + CW'(p_valid) - CW'(deq);
  assign rd_accept = mmio_rd_valid && (occ_next < CW'(RSP_FIFO_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      p_valid         <= 1'b0;
      fifo_cnt        <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      sticky_overflow <= 1'b0;
    end else begin
      p_valid  <= rd_accept;
      fifo_cnt <= occ_next;
      if (p_valid) wr_ptr <= wr_ptr + 1'b1;
      if (deq)     rd_ptr <= rd_ptr + 1'b1;
      sticky_overflow <= (sticky_overflow &&
                          !(evt_clr_wr && mmio_wr_data[EVT_CLEAR_OVERFLOW_BIT])) ||
                         (mmio_rd_valid && !rd_accept);
    end
  end

  always_ff @(posedge clk) begin
    p_tid  <= mmio_rd_tid;
    p_data <= rd_data;
    if (p_valid) begin
      mem_tid[wr_ptr]  <= p_tid;
      mem_data[wr_ptr] <= p_data;
    end
  end

endmodule

// File: tb/tb_cci_mpf_csr_ctrl.sv
// Bench for cci_mpf_csr_ctrl: directed scenarios plus random traffic, all
// checked each cycle against a transaction-level reference model.
module tb_cci_mpf_csr_ctrl;
  import cci_mpf_csrs_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CTR_W   = 6;
  localparam int CTR_MAX = (1 << CTR_W) - 1;
`ifdef MPF_CSR_EVENT_COUNTERS_EN
  localparam bit CTRS_EN = 1'b1;
`else
  localparam bit CTRS_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset;
  logic                  mmio_wr_valid;
  logic [3:0]            mmio_wr_idx;
  logic [63:0]           mmio_wr_data;
  logic                  mmio_rd_valid;
  logic [3:0]            mmio_rd_idx;
  logic [8:0]            mmio_rd_tid;
  logic                  rsp_valid;
  logic [8:0]            rsp_tid;
  logic [63:0]           rsp_data;
  logic                  rsp_ready;
  logic [6:0]            evt_in;
  t_cci_mpf_vtp_csr_mode vtp_mode;
  t_cci_clAddr           vtp_pt_base;
  logic                  vtp_pt_base_valid;
  logic [63:0]           vc_map_ctrl;
  logic                  vc_map_ctrl_valid;

  cci_mpf_csr_ctrl #(.RSP_FIFO_DEPTH(DEPTH), .EVT_CTR_BITS(CTR_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .mmio_wr_valid     (mmio_wr_valid),
    .mmio_wr_idx       (mmio_wr_idx),
    .mmio_wr_data      (mmio_wr_data),
    .mmio_rd_valid     (mmio_rd_valid),
    .mmio_rd_idx       (mmio_rd_idx),
    .mmio_rd_tid       (mmio_rd_tid),
    .rsp_valid         (rsp_valid),
    .rsp_tid           (rsp_tid),
    .rsp_data          (rsp_data),
    .rsp_ready         (rsp_ready),
    .evt_in            (evt_in),
    .vtp_mode          (vtp_mode),
    .vtp_pt_base       (vtp_pt_base),
    .vtp_pt_base_valid (vtp_pt_base_valid),
    .vc_map_ctrl       (vc_map_ctrl),
    .vc_map_ctrl_valid (vc_map_ctrl_valid)
  );

  // reference model state
  logic [1:0]  m_mode;
  logic [41:0] m_base;
  logic [63:0] m_vc;
  logic        m_base_v;
  logic        m_vc_v;
  int          m_ctr [7];
  logic        m_sticky;
  int          cyc;

  // scoreboard: accepted reads in order, with the cycle each becomes visible
  logic [63:0] exp_q[$];
  logic [8:0]  exp_tid_q[$];
  int          exp_vis_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit m_rsp_valid();
    return (exp_q.size() > 0) && (exp_vis_q[0] <= cyc);
  endfunction

  function automatic int m_fifo_cnt();
    int n = 0;
    foreach (exp_vis_q[i]) if (exp_vis_q[i] <= cyc) n++;
    return n;
  endfunction

  task automatic model_clear();
    m_mode = '0; m_base = '0; m_vc = '0; m_base_v = 1'b0; m_vc_v = 1'b0;
    m_sticky = 1'b0;
    foreach (m_ctr[i]) m_ctr[i] = 0;
    exp_q.delete(); exp_tid_q.delete(); exp_vis_q.delete();
  endtask

  task automatic compare_outputs();
    check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid()));
    if (m_rsp_valid()) begin
      check("rsp_tid", 64'(rsp_tid), 64'(exp_tid_q[0]));
      check("rsp_data", rsp_data, exp_q[0]);
    end
    check("vtp_mode", 64'(vtp_mode), 64'(m_mode));
    check("vtp_pt_base", 64'(vtp_pt_base), 64'(m_base));
    check("vtp_pt_base_valid", 64'(vtp_pt_base_valid), 64'(m_base_v));
    check("vc_map_ctrl", vc_map_ctrl, m_vc);
    check("vc_map_ctrl_valid", 64'(vc_map_ctrl_valid), 64'(m_vc_v));
  endtask

  task automatic model_update(input bit rst, input bit wv, input logic [3:0] widx,
                              input logic [63:0] wdata, input bit rv,
                              input logic [3:0] ridx, input logic [8:0] rtid,
                              input bit rdy, input logic [6:0] evt);
    bit          deq;
    bit          drop;
    int          pending;
    logic [63:0] rdata;
    logic [63:0] clr;
    if (rst) begin
      model_clear();
      return;
    end
    deq     = m_rsp_valid() && rdy;
    pending = exp_q.size();
    drop    = 1'b0;
    if (rv) begin
      rdata = '0;
      case (ridx)
        4'd0: rdata = 64'(m_mode);
        4'd1: rdata = 64'(m_base);
        4'd2: rdata = m_vc;
        4'd4: rdata = {62'b0, m_sticky, (m_fifo_cnt() == DEPTH)};
        default: if (CTRS_EN && ridx >= 4'd8 && ridx <= 4'd14) rdata = 64'(m_ctr[int'(ridx) - 8]);
      endcase
      if (pending - int'(deq) < DEPTH) begin
        exp_q.push_back(rdata);
        exp_tid_q.push_back(rtid);
        exp_vis_q.push_back(cyc + 2);
      end else begin
        drop = 1'b1;
      end
    end
    if (deq) begin
      void'(exp_q.pop_front());
      void'(exp_tid_q.pop_front());
      void'(exp_vis_q.pop_front());
    end
    m_base_v = wv && (widx == 4'd1);
    m_vc_v   = wv && (widx == 4'd2);
    if (wv) begin
      case (widx)
        4'd0: m_mode = wdata[1:0];
        4'd1: m_base = wdata[41:0];
        4'd2: m_vc   = wdata;
        default: ;
      endcase
    end
    clr = (wv && widx == 4'd3) ? wdata : 64'd0;
    for (int i = 0; i < 7; i++) begin
      if (CTRS_EN) begin
        if (clr[i]) m_ctr[i] = 0;
        else if (evt[i] && m_ctr[i] < CTR_MAX) m_ctr[i]++;
      end
    end
    m_sticky = (m_sticky && !clr[63]) || drop;
  endtask

  // driver: compare the current cycle, drive inputs, advance one clock
  task automatic step(input bit rst, input bit wv, input logic [3:0] widx,
                      input logic [63:0] wdata, input bit rv, input logic [3:0] ridx,
                      input logic [8:0] rtid, input bit rdy, input logic [6:0] evt);
    compare_outputs();
    reset = rst; mmio_wr_valid = wv; mmio_wr_idx = widx; mmio_wr_data = wdata;
    mmio_rd_valid = rv; mmio_rd_idx = ridx; mmio_rd_tid = rtid;
    rsp_ready = rdy; evt_in = evt;
    model_update(rst, wv, widx, wdata, rv, ridx, rtid, rdy, evt);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 9'd0, rdy, 7'd0);
  endtask

  task automatic wr(input logic [3:0] idx, input logic [63:0] data);
    step(1'b0, 1'b1, idx, data, 1'b0, 4'd0, 9'd0, 1'b1, 7'd0);
  endtask

  task automatic rd(input logic [3:0] idx, input logic [8:0] tid, input bit rdy);
    step(1'b0, 1'b0, 4'd0, 64'd0, 1'b1, idx, tid, rdy, 7'd0);
  endtask

  initial begin
    cyc = 0;
    reset = 1'b1; mmio_wr_valid = 1'b0; mmio_wr_idx = '0; mmio_wr_data = '0;
    mmio_rd_valid = 1'b0; mmio_rd_idx = '0; mmio_rd_tid = '0;
    rsp_ready = 1'b1; evt_in = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // page-table base write and readback latency
    wr(4'd1, 64'h1_2345_6789);
    check("pt_base_value", 64'(vtp_pt_base), 64'h1_2345_6789);
    check("pt_base_pulse", 64'(vtp_pt_base_valid), 64'd1);
    idle(1'b1);
    check("pt_base_pulse_end", 64'(vtp_pt_base_valid), 64'd0);
    rd(4'd1, 9'd5, 1'b1);
    idle(1'b1);
    check("rd_lat_valid", 64'(rsp_valid), 64'd1);
    check("rd_lat_tid", 64'(rsp_tid), 64'd5);
    check("rd_lat_data", rsp_data, 64'h1_2345_6789);
    idle(1'b1);

    // event counting and clear-over-increment
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 9'd0, 1'b1, 7'h04);
    rd(4'd10, 9'd1, 1'b1);
    idle(1'b1);
    check("evt2_count", rsp_data, CTRS_EN ? 64'd10 : 64'd0);
    step(1'b0, 1'b1, 4'd3, 64'h4, 1'b0, 4'd0, 9'd0, 1'b1, 7'h04);
    rd(4'd10, 9'd2, 1'b1);
    idle(1'b1);
    check("evt2_cleared", rsp_data, 64'd0);
    idle(1'b1);

    // saturation on every counter, then read them all back-to-back
    for (int i = 0; i < CTR_MAX + 5; i++) step(1'b0, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 9'd0, 1'b1, 7'h7f);
    for (int i = 8; i <= 14; i++) rd(4'(i), 9'(i), 1'b1);
    repeat (3) idle(1'b1);

    // overflow: six reads with no drain, STATUS while full, drain
    for (int i = 0; i < 6; i++) rd(4'd0, 9'(i), 1'b0);
    repeat (2) idle(1'b0);
    rd(4'd4, 9'd6, 1'b1);
    repeat (8) idle(1'b1);
    rd(4'd4, 9'd7, 1'b1);
    idle(1'b1);
    check("status_after_drain", rsp_data, 64'h2);
    wr(4'd3, 64'h8000_0000_0000_0000);
    rd(4'd4, 9'd8, 1'b1);
    repeat (3) idle(1'b1);

    // reset with reads queued
    wr(4'd0, 64'h3);
    wr(4'd2, 64'hdead_beef_0123_4567);
    for (int i = 0; i < 3; i++) rd(4'd2, 9'(20 + i), 1'b0);
    idle(1'b0);
    step(1'b1, 1'b0, 4'd0, 64'd0, 1'b0, 4'd0, 9'd0, 1'b0, 7'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    for (int i = 0; i < 3; i++) rd(4'(i), 9'(30 + i), 1'b1);
    repeat (4) idle(1'b1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)),
           {$urandom, $urandom},
           ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)),
           9'($urandom), ($urandom_range(0, 2) != 0), 7'($urandom));
    end
    repeat (8) idle(1'b1);
    check("final_drained", 64'(rsp_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cci_mpf_csr_ctrl.md
CCI_MPF_CSR_CTRL -- requirements
Module: cci_mpf_csr_ctrl

Interface
REQ-001 SHALL have parameter RSP_FIFO_DEPTH, default 4, read-response buffer entries (power of 2, >=2).
REQ-002 SHALL have parameter EVT_CTR_BITS, default 48, event counter width.
REQ-003 SHALL have port clk  in  1  sole clock; one clock, all logic on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port mmio_wr_valid  in  1  host CSR write strobe.
REQ-006 SHALL have port mmio_wr_idx  in  4  64-bit CSR word index.
REQ-007 SHALL have port mmio_wr_data  in  64  write data.
REQ-008 SHALL have port mmio_rd_valid  in  1  host CSR read strobe, no flow control.
REQ-009 SHALL have port mmio_rd_idx  in  4  read word index.
REQ-010 SHALL have port mmio_rd_tid  in  9  read transaction ID.
REQ-011 SHALL have ports rsp_valid  out  1, rsp_tid  out  9, rsp_data  out  64  read response.
REQ-012 SHALL have port rsp_ready  in  1  TX arbiter accepts response.
REQ-013 SHALL have port evt_in  in  7  event pulses: [0] 4KB hit, [1] 4KB miss, [2] 2MB hit, [3] 2MB miss, [4] PT walk busy, [5] failed translation, [6] VC mapping changed.
REQ-014 SHALL have ports vtp_mode  out  t_cci_mpf_vtp_csr_mode; vtp_pt_base  out  t_cci_clAddr; vtp_pt_base_valid  out  1; vc_map_ctrl  out  64; vc_map_ctrl_valid  out  1.

Function
REQ-015 SHALL decode writes: idx 0 -> vtp_mode, idx 1 -> vtp_pt_base (data[t_cci_clAddr width-1:0]), idx 2 -> vc_map_ctrl, idx 3 -> EVT_CLEAR (bit i clears counter i); other indices ignored.
REQ-016 SHALL update config outputs the cycle after the write strobe; vtp_pt_base_valid and vc_map_ctrl_valid SHALL be one-cycle pulses aligned with the update.
REQ-017 SHALL maintain seven EVT_CTR_BITS counters, +1 per cycle when evt_in[i]=1, saturating at all-ones.
REQ-018 SHALL give clear priority over a simultaneous increment (result 0).
REQ-019 SHALL decode reads: idx 0-2 return current config (zero-extended), idx 3 returns 0, idx 4 STATUS ({62'b0, sticky_overflow, fifo_full}), idx 8-14 counters 0-6 zero-extended, others 0.
REQ-020 SHALL capture read data in cycle N into a pipeline register and enqueue in cycle N+1; with empty FIFO and rsp_ready=1, rsp_valid SHALL assert in cycle N+2.
REQ-021 SHALL pop the FIFO head when rsp_valid & rsp_ready; rsp_valid/rsp_tid/rsp_data SHALL hold while rsp_ready=0.
REQ-022 SHALL drop a read arriving with the FIFO full (counting the in-flight pipeline entry) and set sticky_overflow; sticky_overflow SHALL clear only on reset or EVT_CLEAR write with bit 63=1.
REQ-023 SHALL support enqueue and dequeue in the same cycle at full occupancy without loss.
REQ-024 SHALL process a write and a read in the same cycle; read returns pre-write value.

Reset
REQ-025 SHALL on reset zero vtp_mode, vtp_pt_base, vc_map_ctrl, all counters and sticky_overflow; deassert rsp_valid, both valid pulses; empty FIFO and pipeline.
REQ-026 SHALL discard any reads queued or in flight when reset asserts mid-operation; no response after reset.

Configuration
REQ-027 SHALL compile counters only when MPF_CSR_EVENT_COUNTERS_EN is defined; without it evt_in is ignored, idx 8-14 read 0, EVT_CLEAR bits 0-6 have no effect, bit 63 still clears overflow.

Structure
REQ-028 SHALL place CSR index constants, event bit positions and the STATUS layout in cci_mpf_csrs_pkg.
REQ-029 SHALL instantiate sub-module cci_mpf_csr_evt_ctr (one saturating counter with clear/increment) seven times.

Verification
REQ-030 Write idx 1 data 0x123456789 -> vtp_pt_base=0x123456789 and one-cycle vtp_pt_base_valid the next cycle; read idx 1 tid 5 -> rsp_tid=5, rsp_data=0x123456789 at N+2.
REQ-031 Hold evt_in[2]=1 for 10 cycles, read idx 10 -> 10; EVT_CLEAR 0x4 same cycle as evt_in[2] -> counter reads 0.
REQ-032 Force counter to all-ones minus 1, pulse 3 events -> reads 0xFFFF_FFFF_FFFF (EVT_CTR_BITS=48).
REQ-033 rsp_ready=0, issue 6 back-to-back reads tid 0-5 -> tids 0-3 returned in order, 4-5 dropped, STATUS=0x3 when full, bit1 persists after draining.
REQ-034 Assert reset with 3 reads queued -> rsp_valid=0 next cycle, no stale responses, all config reads 0.
REQ-035 Build without MPF_CSR_EVENT_COUNTERS_EN, pulse all events -> idx 8-14 read 0.
